// File: rtl/clint_timer_pkg.sv
// -----------------------------------------------------------------------------
// clint_timer_pkg
// Shared definitions for the core-local interruptor:
//   - CLINT window offsets for msip, ssip, mtimecmp and mtime
//   - default bus width selected by the RV64I build define
//   - bus FSM state encoding and register-select encoding
//   - clint_decode(): maps a byte offset onto the register it addresses
// -----------------------------------------------------------------------------
package clint_timer_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_SSIP        = 16'h0004;
  localparam logic [15:0] CLINT_MTIMECMP    = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME       = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

`ifdef RV64I
  localparam int DATA_SIZE_DEF = 64;
`else
  localparam int DATA_SIZE_DEF = 32;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_MSIP    = 3'd1,
    REG_SSIP    = 3'd2,
    REG_CMP_LO  = 3'd3,
    REG_CMP_HI  = 3'd4,
    REG_TIME_LO = 3'd5,
    REG_TIME_HI = 3'd6
  } clint_reg_e;

  // Sub-word offsets resolve to their containing 32-bit word. On a 64-bit
  // bus the upper-half words of the timer pair are not addressable.
  function automatic clint_reg_e clint_decode(input logic [15:0] addr,
                                              input logic        wide);
    logic [15:0] word;
    clint_reg_e  sel;
    word = addr & 16'hFFFC;
    case (word)
      CLINT_MSIP:        sel = REG_MSIP;
      CLINT_SSIP:        sel = REG_SSIP;
      CLINT_MTIMECMP:    sel = REG_CMP_LO;
      CLINT_MTIMECMP_HI: sel = wide ? REG_NONE : REG_CMP_HI;
      CLINT_MTIME:       sel = REG_TIME_LO;
      CLINT_MTIME_HI:    sel = wide ? REG_NONE : REG_TIME_HI;
      default:           sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clint_byte_reg64.sv
// -----------------------------------------------------------------------------
// clint_byte_reg64
// 64-bit register with byte-lane write masking, used for mtime and mtimecmp.
// On a 32-bit bus the write lands in the half chosen by wr_hi_i.
// A bus write touching any byte wins over the update path for the whole
// register in that cycle; untouched bytes keep their previous value.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   upd_en_i         load upd_val_i this cycle (e.g. timer increment)
//   upd_val_i        64-bit update value
//   wr_en_i          bus write targets this register
//   wr_hi_i          32-bit bus only: write targets bits [63:32]
//   wr_sel_i         bus byte enables
//   wr_data_i        bus write data
//   q_o              registered register value
// -----------------------------------------------------------------------------
module clint_byte_reg64 #(
  parameter int          DATA_SIZE = 32,
  parameter logic [63:0] RST_VAL   = 64'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   upd_en_i,
  input  logic [63:0]            upd_val_i,
  input  logic                   wr_en_i,
  input  logic                   wr_hi_i,
  input  logic [DATA_SIZE/8-1:0] wr_sel_i,
  input  logic [DATA_SIZE-1:0]   wr_data_i,
  output logic [63:0]            q_o
);

  logic [7:0]  lane_mask_s;
  logic [63:0] lane_data_s;
  logic        wr_any_s;
  logic [63:0] base_s;
  logic [63:0] reg_d;
  logic [63:0] reg_q;

  generate
    if (DATA_SIZE == 64) begin : g_wide
      logic unused_hi_s;
      assign unused_hi_s = wr_hi_i;
      assign lane_mask_s = wr_sel_i;
      assign lane_data_s = wr_data_i;
    end else begin : g_narrow
      // Data is replicated into both halves; the lane mask picks the half.
      assign lane_mask_s = wr_hi_i ? {wr_sel_i, 4'h0} : {4'h0, wr_sel_i};
      assign lane_data_s = {wr_data_i, wr_data_i};
    end
  endgenerate

  assign wr_any_s = wr_en_i & (|lane_mask_s);

  // Next-state: update path unless a write touches any byte, then overlay lanes.
  always_comb begin
    base_s = reg_q;
    reg_d  = reg_q;
    if (upd_en_i && !wr_any_s) begin
      base_s = upd_val_i;
    end else begin
      base_s = reg_q;
    end
    for (int b = 0; b < 8; b++) begin
      if (wr_en_i && lane_mask_s[b]) begin
        reg_d[b*8 +: 8] = lane_data_s[b*8 +: 8];
      end else begin
        reg_d[b*8 +: 8] = base_s[b*8 +: 8];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_q <= RST_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q_o = reg_q;

endmodule

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Core-local interruptor slave: msip/ssip software-interrupt bits and the
// 64-bit mtime/mtimecmp pair, exported to the CSR file. The timer compare is
// done in the CSR, not here.
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   wb_cyc, wb_stb   bus cycle / strobe; request when both high
//   wb_we            1 = write, 0 = read
//   wb_addr          byte offset within the CLINT window
//   wb_sel           write byte enables
//   wb_dat_w         write data
//   wb_dat_r         read data, valid with wb_ack
//   wb_ack           one-cycle acknowledge, one cycle after the request
//   mem_msip/ssip    software-interrupt pending bits
//   mem_mtime        current mtime
//   mem_mtimecmp     current mtimecmp
// -----------------------------------------------------------------------------
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PRESCALE  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [15:0]            wb_addr,
  input  logic [DATA_SIZE/8-1:0] wb_sel,
  input  logic [DATA_SIZE-1:0]   wb_dat_w,
  output logic [DATA_SIZE-1:0]   wb_dat_r,
  output logic                   wb_ack,
  output logic                   mem_msip,
  output logic                   mem_ssip,
  output logic [63:0]            mem_mtime,
  output logic [63:0]            mem_mtimecmp
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  bus_state_e             state_q;
  logic                   ack_q;
  logic [DATA_SIZE-1:0]   dat_r_q;
  logic                   msip_q, msip_d;
  logic                   ssip_q, ssip_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick_s;
  logic                   accept_s;
  logic                   wr_fire_s;
  clint_reg_e             reg_s;
  logic [63:0]            mtime_s;
  logic [63:0]            mtimecmp_s;
  logic [63:0]            rd64_s;
  logic [DATA_SIZE-1:0]   rdata_s;
  logic                   time_wr_s;
  logic                   cmp_wr_s;

  assign reg_s     = clint_decode(wb_addr, DATA_SIZE == 64);
  assign accept_s  = (state_q == ST_IDLE) & wb_cyc & wb_stb;
  assign wr_fire_s = accept_s & wb_we;
  assign time_wr_s = wr_fire_s & ((reg_s == REG_TIME_LO) | (reg_s == REG_TIME_HI));
  assign cmp_wr_s  = wr_fire_s & ((reg_s == REG_CMP_LO)  | (reg_s == REG_CMP_HI));

  // Read-data mux; unmapped offsets read as zero.
  always_comb begin
    rd64_s = 64'h0;
    case (reg_s)
      REG_MSIP:    rd64_s = {63'h0, msip_q};
      REG_SSIP:    rd64_s = {63'h0, ssip_q};
      REG_CMP_LO: begin
        if (DATA_SIZE == 64) begin
          rd64_s = mtimecmp_s;
        end else begin
          rd64_s = {32'h0, mtimecmp_s[31:0]};
        end
      end
      REG_CMP_HI:  rd64_s = {32'h0, mtimecmp_s[63:32]};
      REG_TIME_LO: begin
        if (DATA_SIZE == 64) begin
          rd64_s = mtime_s;
        end else begin
          rd64_s = {32'h0, mtime_s[31:0]};
        end
      end
      REG_TIME_HI: rd64_s = {32'h0, mtime_s[63:32]};
      default:     rd64_s = 64'h0;
    endcase
  end

  assign rdata_s = rd64_s[DATA_SIZE-1:0];

  // Bus FSM: accept in IDLE, acknowledge for exactly one cycle in ACK.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_r_q <= {DATA_SIZE{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_r_q <= rdata_s;
          end else begin
            ack_q   <= 1'b0;
            dat_r_q <= {DATA_SIZE{1'b0}};
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_r_q <= {DATA_SIZE{1'b0}};
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_r_q <= {DATA_SIZE{1'b0}};
        end
      endcase
    end
  end

  // Software-interrupt bits: only bit 0 of byte lane 0 is stored.
  always_comb begin
    msip_d = msip_q;
    ssip_d = ssip_q;
    if (wr_fire_s && wb_sel[0]) begin
      if (reg_s == REG_MSIP) begin
        msip_d = wb_dat_w[0];
      end else if (reg_s == REG_SSIP) begin
        ssip_d = wb_dat_w[0];
      end else begin
        msip_d = msip_q;
        ssip_d = ssip_q;
      end
    end else begin
      msip_d = msip_q;
      ssip_d = ssip_q;
    end
  end

  // Software-interrupt bit storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip_q <= 1'b0;
      ssip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
      ssip_q <= ssip_d;
    end
  end

  // Prescaler: counts 0..PRESCALE-1, tick on wrap. Bus writes do not touch it.
  always_comb begin
    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  clint_byte_reg64 #(
    .DATA_SIZE (DATA_SIZE),
    .RST_VAL   (64'h0)
  ) u_mtime (
    .clock     (clock),
    .reset     (reset),
    .upd_en_i  (tick_s),
    .upd_val_i (mtime_s + 64'd1),
    .wr_en_i   (time_wr_s),
    .wr_hi_i   (reg_s == REG_TIME_HI),
    .wr_sel_i  (wb_sel),
    .wr_data_i (wb_dat_w),
    .q_o       (mtime_s)
  );

  clint_byte_reg64 #(
    .DATA_SIZE (DATA_SIZE),
    .RST_VAL   (64'hFFFF_FFFF_FFFF_FFFF)
  ) u_mtimecmp (
    .clock     (clock),
    .reset     (reset),
    .upd_en_i  (1'b0),
    .upd_val_i (64'h0),
    .wr_en_i   (cmp_wr_s),
    .wr_hi_i   (reg_s == REG_CMP_HI),
    .wr_sel_i  (wb_sel),
    .wr_data_i (wb_dat_w),
    .q_o       (mtimecmp_s)
  );

  assign wb_ack       = ack_q;
  assign wb_dat_r     = dat_r_q;
  assign mem_msip     = msip_q;
  assign mem_ssip     = ssip_q;
  assign mem_mtime    = mtime_s;
  assign mem_mtimecmp = mtimecmp_s;

endmodule
